move_cmd_gen: RTL
=================

Name: move_cmd_gen

Overview:
Upstream command stage for the position-mover block. Converts two raw push-buttons (left/right) into the mover's 2-bit `oper` command. Provides synchronisation, debounce, a single step on press and timed auto-repeat while held. Uses the mover's limit flags to suppress steps that would cross a bound.

Parameters:
- DB_CYCLES, 16, consecutive stable synchronised samples required to change a debounced button state (>=1)
- HOLD_CYCLES, 64, cycles from the first step to the first auto-repeat step (>=1)
- REP_CYCLES, 8, cycles between auto-repeat steps (>=1)
- CNT_W, 16, width of internal timer counters; must hold max(DB_CYCLES, HOLD_CYCLES, REP_CYCLES)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_left  in  1  raw left button, asynchronous, active-high
- btn_right  in  1  raw right button, asynchronous, active-high
- at_min  in  1  mover position at lower limit; decrement forbidden
- at_max  in  1  mover position at upper limit; increment forbidden
- oper  out  2  command to mover: 2'b10 increment (right), 2'b01 decrement (left), 2'b00 hold; registered
- moving  out  1  high while FSM is not IDLE; registered
- limit_hit  out  1  one-cycle pulse when a step is suppressed by at_min/at_max; registered

Behaviour:
- Reset (sampled on posedge clk while reset=1):
  - oper=2'b00, moving=0, limit_hit=0.
  - Synchroniser flops, debounced states and all counters cleared.
  - FSM set to IDLE.
  - Reset mid-hold aborts the sequence. A button still held after reset must re-debounce before any step.
- Synchroniser: 2 flops per button.
- Debounce, per button:
  - Counter increments each cycle the synchronised sample differs from the debounced state.
  - Counter clears whenever they match.
  - When the counter reaches DB_CYCLES, the debounced state toggles and the counter clears.
  - Glitches shorter than DB_CYCLES cycles never reach the FSM.
- Latency: raw edge first sampled at edge k, stable thereafter → debounced state toggles at edge k+1+DB_CYCLES → first oper pulse visible in the cycle after edge k+2+DB_CYCLES.
- Direction request dir:
  - RIGHT if db_right & ~db_left.
  - LEFT if db_left & ~db_right.
  - NONE otherwise; both pressed = NONE.
- FSM states: IDLE, STEP, HOLD, REPEAT.
  - IDLE: dir != NONE → STEP and latch dir.
  - STEP: emit one step; load timer with HOLD_CYCLES; → HOLD.
  - HOLD: timer decrements each cycle. At timer==1 emit one step, reload REP_CYCLES, → REPEAT.
  - REPEAT: timer decrements each cycle. At timer==1 emit one step and reload REP_CYCLES.
  - Any state other than IDLE: dir differs from the latched dir (release, reversal or both pressed) → IDLE the same edge, no step emitted.
  - Reversal therefore costs one IDLE cycle, then STEP in the new direction.
- Step emission:
  - oper = 2'b10 (RIGHT) or 2'b01 (LEFT) for exactly one cycle.
  - oper = 2'b00 in all other cycles; never two consecutive non-zero cycles.
- Limit suppression:
  - If a step is due and (RIGHT & at_max) or (LEFT & at_min), oper stays 2'b00 and limit_hit pulses 1 cycle.
  - FSM timing is unchanged; repeats resume on the next due slot once the flag clears.
  - Limit flags are sampled in the same cycle the step is generated.
- moving = 1 in STEP/HOLD/REPEAT, 0 in IDLE; updated with the state register.
- All counters saturate-free by construction: loaded values <= 2^CNT_W-1. Parameters violating this are illegal.

Optional Feature:
- Macro: MOVE_ACCEL_EN.
- Defined:
  - After 4 consecutive REPEAT steps (suppressed ones count), the reload value becomes max(REP_CYCLES>>1, 1) until the FSM returns to IDLE.
  - The repeat counter resets in IDLE.
- Undefined: reload is always REP_CYCLES; no extra counter logic synthesised.

Test Plan:
Bench uses DB_CYCLES=4, HOLD_CYCLES=10, REP_CYCLES=3, unless noted.
1. Reset held 3 cycles with btn_right=1 → oper=00, moving=0 throughout; after release, first oper=10 appears exactly DB_CYCLES+3 cycles after the first post-reset sampling edge.
2. btn_left glitch high for 3 cycles → oper stays 00, moving stays 0.
3. btn_right held 30 cycles from debounce → oper=10 pulses at relative cycles 0, 10, 13, 16, 19, 22, 25, 28, each 1 cycle wide; release → moving=0 within DB_CYCLES+3 cycles, no further pulses.
4. btn_right held, at_max=1 from cycle 5 to 14 → pulse at 0 present; steps due at 10 and 13 give oper=00 with limit_hit=1; pulse at 16 is oper=10.
5. Hold right, then press left as well → FSM to IDLE, oper=00; release right → one IDLE cycle, then STEP with oper=01.
6. MOVE_ACCEL_EN defined, REP_CYCLES=4 → repeat pulses at 10, 14, 18, 22, 26, then spacing 2 (28, 30, …); undefined → spacing stays 4.

Source files
------------

// File: rtl/move_cmd_gen.sv
// Turns raw left/right push-buttons into the mover's oper command: sync, debounce, single step, timed auto-repeat, limit suppression.
// Optional build macro MOVE_ACCEL_EN: repeat interval halves after four consecutive repeat steps.
module move_cmd_gen #(
  parameter int DB_CYCLES   = 16,
  parameter int HOLD_CYCLES = 64,
  parameter int REP_CYCLES  = 8,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       at_min,
  input  logic       at_max,
  output logic [1:0] oper,
  output logic       moving,
  output logic       limit_hit
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REP_LD    = CNT_W'(REP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, STEP, HOLD, REPEAT} state_t;
  // Direction codes double as the oper encoding.
  typedef enum logic [1:0] {DIR_NONE = 2'b00, DIR_LEFT = 2'b01, DIR_RIGHT = 2'b10} dir_t;

  logic [1:0] btn_raw;
  logic [1:0] db_w;

  assign btn_raw = {btn_right, btn_left};

  // Index 0 = left, 1 = right.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic             sync1_q;
      logic             sync2_q;
      logic             db_q;
      logic             db_d;
      logic [CNT_W-1:0] db_cnt_q;
      logic [CNT_W-1:0] db_cnt_d;

      always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (sync2_q != db_q) begin
          if (db_cnt_q == DB_LAST) begin
            db_d = ~db_q;
          end else begin
            db_cnt_d = db_cnt_q + CNT_ONE;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_q  <= 1'b0;
          sync2_q  <= 1'b0;
          db_q     <= 1'b0;
          db_cnt_q <= '0;
        end else begin
          sync1_q  <= btn_raw[gi];
          sync2_q  <= sync1_q;
          db_q     <= db_d;
          db_cnt_q <= db_cnt_d;
        end
      end

      assign db_w[gi] = db_q;
    end
  endgenerate

  dir_t dir;

  always_comb begin
    dir = DIR_NONE;
    if (db_w[1] && !db_w[0]) begin
      dir = DIR_RIGHT;
    end else if (db_w[0] && !db_w[1]) begin
      dir = DIR_LEFT;
    end
  end

  state_t           state_q;
  state_t           state_d;
  dir_t             dir_lat_q;
  dir_t             dir_lat_d;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;
  logic [CNT_W-1:0] rep_reload;
  logic [1:0]       oper_q;
  logic [1:0]       oper_d;
  logic             moving_q;
  logic             moving_d;
  logic             limit_q;
  logic             limit_d;
  logic             step_due;

`ifdef MOVE_ACCEL_EN
  localparam int               REP_FAST_I = (REP_CYCLES > 1) ? (REP_CYCLES >> 1) : 1;
  localparam logic [CNT_W-1:0] REP_FAST   = CNT_W'(REP_FAST_I);

  // Saturates at 3: the fourth repeat step and all later ones reload the fast interval.
  logic [1:0] rep_cnt_q;
  logic [1:0] rep_cnt_d;

  always_comb begin
    rep_cnt_d = rep_cnt_q;
    if (state_q == IDLE) begin
      rep_cnt_d = 2'd0;
    end else if (state_q == REPEAT && timer_q == CNT_ONE && rep_cnt_q != 2'd3) begin
      rep_cnt_d = rep_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_q <= 2'd0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end

  assign rep_reload = (rep_cnt_q == 2'd3) ? REP_FAST : REP_LD;
`else
  assign rep_reload = REP_LD;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_lat_q <= DIR_NONE;
      timer_q   <= '0;
      oper_q    <= 2'b00;
      moving_q  <= 1'b0;
      limit_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_lat_q <= dir_lat_d;
      timer_q   <= timer_d;
      oper_q    <= oper_d;
      moving_q  <= moving_d;
      limit_q   <= limit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_lat_d = dir_lat_q;
    timer_d   = timer_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (dir != DIR_NONE) begin
          state_d   = STEP;
          dir_lat_d = dir;
        end
      end
      STEP: begin
        if (dir != dir_lat_q) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          state_d = HOLD;
          timer_d = HOLD_LD;
        end
      end
      HOLD: begin
        if (dir != dir_lat_q) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == CNT_ONE) begin
          state_d = REPEAT;
          timer_d = REP_LD;
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      REPEAT: begin
        if (dir != dir_lat_q) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == CNT_ONE) begin
          timer_d = rep_reload;
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Outputs are registered, so they are derived from the next-state view: the step shows up
  // in the same cycle the FSM sits in STEP, or in HOLD/REPEAT with the timer at 1.
  always_comb begin
    oper_d   = 2'b00;
    limit_d  = 1'b0;
    moving_d = (state_d != IDLE);
    step_due = (state_d == STEP) ||
               ((state_d == HOLD || state_d == REPEAT) && timer_d == CNT_ONE);
    if (step_due) begin
      if ((dir_lat_d == DIR_RIGHT && at_max) || (dir_lat_d == DIR_LEFT && at_min)) begin
        limit_d = 1'b1;
      end else begin
        oper_d = dir_lat_d;
      end
    end
  end

  assign oper      = oper_q;
  assign moving    = moving_q;
  assign limit_hit = limit_q;

endmodule
